// File: rtl/daq3_spi_responder.sv
`timescale 1ns/1ps
// daq3_spi_responder: 3-wire SPI register-file responder (16-bit instruction, streaming bytes)
module daq3_spi_responder #(
    parameter logic [7:0] CHIP_ID  = 8'hC5,
    parameter int         NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_csn,
    input  logic                  spi_clk,
    input  logic                  spi_sdio_i,
    output logic                  spi_sdio_o,
    output logic                  spi_sdio_t,
    output logic                  wr_strobe,
    output logic [14:0]           wr_addr,
    output logic [7:0]            wr_data,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_INSTR, S_WRITE, S_READ} state_t;
    state_t      r_state, w_next;
    logic [2:0]  r_csn_sync, r_clk_sync, r_sdio_sync;
    logic        r_armed, r_rise, r_fall, r_csn_fall, r_csn_rise;
    logic [4:0]  r_icnt;
    logic [2:0]  r_dcnt;
    logic [14:0] r_sr;
    logic [6:0]  r_rsr;
    logic [14:0] r_addr;
    logic [7:0]  r_regs [NUM_REGS];
    logic        w_rise, w_fall, w_bit, w_store;
    logic [15:0] w_instr;
    logic [7:0]  w_wr_byte, w_rd_byte;

    assign w_rise    = r_rise & ~r_csn_rise;
    assign w_fall    = r_fall & ~r_csn_rise;
    assign w_bit     = r_sdio_sync[2];
    assign w_instr   = {r_sr, w_bit};
    assign w_wr_byte = w_instr[7:0];
    assign w_store   = (r_state == S_WRITE) & w_rise & (r_dcnt == 3'd7) & ~r_csn_fall;
    assign busy      = r_state != S_IDLE;

    // Synchronize pins, arm once csn is seen high, and register edge events one cycle before use.
    // The csn chain resets low so a csn held low through reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csn_sync  <= 3'b000;
            r_clk_sync  <= 3'b000;
            r_sdio_sync <= 3'b000;
            r_armed     <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_csn_fall  <= 1'b0;
            r_csn_rise  <= 1'b0;
        end else begin
            r_csn_sync  <= {r_csn_sync[1:0], spi_csn};
            r_clk_sync  <= {r_clk_sync[1:0], spi_clk};
            r_sdio_sync <= {r_sdio_sync[1:0], spi_sdio_i};
            r_armed     <= r_armed | r_csn_sync[1];
            r_rise      <= r_armed & ~r_csn_sync[1] & r_clk_sync[1] & ~r_clk_sync[2];
            r_fall      <= r_armed & ~r_csn_sync[1] & ~r_clk_sync[1] & r_clk_sync[2];
            r_csn_fall  <= r_armed & ~r_csn_sync[1] & r_csn_sync[2];
            r_csn_rise  <= r_armed & r_csn_sync[1] & ~r_csn_sync[2];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // Next state: csn_rise aborts, csn_fall (re)starts, 16th instruction rise picks direction.
    always_comb begin
        w_next = r_state;
        if (r_csn_rise) w_next = S_IDLE;
        else if (r_csn_fall) w_next = S_INSTR;
        else if (r_state == S_INSTR && w_rise && r_icnt == 5'd15) w_next = w_instr[15] ? S_READ : S_WRITE;
    end

    // Read-back mux: chip id overrides storage at its address, unmapped addresses read zero.
    always_comb begin
        w_rd_byte = 8'h00;
        for (int n = 0; n < NUM_REGS; n++)
            if (r_addr == 15'(n)) w_rd_byte = r_regs[n];
        if (r_addr == 15'd4) w_rd_byte = CHIP_ID;
    end

    // Shift/count datapath, write strobe and SDIO driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_icnt     <= 5'd0;
            r_dcnt     <= 3'd0;
            r_sr       <= 15'd0;
            r_rsr      <= 7'd0;
            r_addr     <= 15'd0;
            spi_sdio_o <= 1'b0;
            spi_sdio_t <= 1'b1;
            wr_strobe  <= 1'b0;
            wr_addr    <= 15'd0;
            wr_data    <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (r_csn_rise) begin
                spi_sdio_t <= 1'b1;
            end else if (r_csn_fall) begin
                r_icnt     <= 5'd0;
                r_dcnt     <= 3'd0;
                spi_sdio_t <= 1'b1;
            end else if (r_state == S_INSTR && w_rise) begin
                r_sr   <= w_instr[14:0];
                r_icnt <= r_icnt + 5'd1;
                if (r_icnt == 5'd15) r_addr <= w_instr[14:0];
            end else if (r_state == S_WRITE && w_rise) begin
                r_sr   <= w_instr[14:0];
                r_dcnt <= r_dcnt + 3'd1;
                if (w_store) begin
                    wr_strobe <= 1'b1;
                    wr_addr   <= r_addr;
                    wr_data   <= w_wr_byte;
                    r_addr    <= r_addr + 15'd1;
                end
            end else if (r_state == S_READ && w_fall) begin
                r_dcnt <= r_dcnt + 3'd1;
                if (r_dcnt == 3'd0) begin
                    r_rsr      <= w_rd_byte[6:0];
                    spi_sdio_o <= w_rd_byte[7];
                    spi_sdio_t <= 1'b0;
                    r_addr     <= r_addr + 15'd1;
                end else begin
                    r_rsr      <= {r_rsr[5:0], 1'b0};
                    spi_sdio_o <= r_rsr[6];
                end
            end
        end
    end

    // Storage registers; the chip-id address is read-only.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NUM_REGS; n++)
            if (rst) r_regs[n] <= 8'h00;
            else if (w_store && r_addr == 15'(n) && n != 4) r_regs[n] <= w_wr_byte;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[8*g +: 8] = r_regs[g];
    end
endmodule
